// File: rtl/boa_mem_bus_if.sv
// boa_mem_bus: word-wide request/ready memory bus shared by the CPU, the
// external-memory cache and the SRAM controller.
//   re     read request
//   we     byte write enables (any bit set = write request)
//   addr   byte address
//   wdata  write data
//   rdata  read data, valid only in the completing cycle
//   ready  slave idle / completion strobe
// The CPU modport is the requesting side; the MEM modport is the responding side.
interface boa_mem_bus #(
  parameter int alen = 16
);
  logic            re;
  logic [3:0]      we;
  logic [alen-1:0] addr;
  logic [31:0]     wdata;
  logic [31:0]     rdata;
  logic            ready;

  modport CPU (output re, we, addr, wdata, input rdata, ready);
  modport MEM (input re, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/boa_extmem_cache.sv
// boa_extmem_cache: direct-mapped, write-through, no-write-allocate cache of
// 32-bit words in front of the byte-wide external SRAM controller. Read hits
// complete one cycle after acceptance; read misses fill one line from the
// controller; every write is forwarded downstream and patches a cached copy.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   cpu         upstream bus (this block is the responder)
//   mem         downstream bus to the SRAM controller (this block requests)
//   flush       one-cycle pulse, invalidates every line
//   hit_count   completed read hits (wrapping)
//   miss_count  completed read misses (wrapping)
module boa_extmem_cache #(
  parameter int alen  = 16,
  parameter int lines = 16
) (
  input  logic        clk,
  input  logic        rst,
  boa_mem_bus.MEM     cpu,
  boa_mem_bus.CPU     mem,
  input  logic        flush,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int IW = $clog2(lines);
  localparam int TW = alen - 2 - IW;

  // WR_ISSUE is the cycle the write is presented downstream; WR_WAIT waits
  // for its completion. Splitting them keeps a controller that idles with
  // ready=1 from being mistaken for a completion in the issue cycle.
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_FILL,
    S_WR_ISSUE,
    S_WR_WAIT
  } state_t;

  state_t state, state_nxt;

  logic [lines-1:0] valid;
  logic [TW-1:0]    tag_mem  [lines];
  logic [31:0]      data_mem [lines];

  logic [alen-1:0]  addr_q;
  logic [3:0]       we_q;
  logic [31:0]      wdata_q;
  logic             flush_pending;

  logic [IW-1:0]    idx_q, idx_in;
  logic [TW-1:0]    tag_q, tag_in;
  logic             lookup_hit;

  logic             cpu_ready;
  logic             mem_re;
  logic [3:0]       mem_we;
  logic             fill_done;
  logic             hit_evt;
  logic             flush_do;

  logic             acc_wr, acc_rd;
  logic             same_line;
  logic             wr_hit;
  logic [31:0]      wr_base;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  assign idx_q  = addr_q[2 +: IW];
  assign tag_q  = addr_q[alen-1 -: TW];
  assign idx_in = cpu.addr[2 +: IW];
  assign tag_in = cpu.addr[alen-1 -: TW];

  assign lookup_hit = valid[idx_q] && (tag_mem[idx_q] == tag_q);

  // Any cycle with cpu.ready=1 is a slave-idle cycle, so a request present
  // then is accepted. A request with both re and we set is a write.
  assign acc_wr = cpu_ready && (cpu.we != 4'b0000);
  assign acc_rd = cpu_ready && (cpu.we == 4'b0000) && cpu.re;

  // A write accepted in the fill completion cycle must see the line being
  // installed, not the stale one, or the fill would overwrite the patch.
  assign same_line = fill_done && (idx_in == idx_q);
  assign wr_hit    = acc_wr && (same_line ? (tag_in == tag_q)
                                          : (valid[idx_in] && (tag_mem[idx_in] == tag_in)));
  assign wr_base   = same_line ? mem.rdata : data_mem[idx_in];

  always_comb begin
    state_nxt = state;
    cpu_ready = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 4'b0000;
    fill_done = 1'b0;
    hit_evt   = 1'b0;
    flush_do  = 1'b0;
    case (state)
      S_IDLE: begin
        cpu_ready = 1'b1;
        flush_do  = flush_pending;
      end
      S_LOOKUP: begin
        if (lookup_hit) begin
          cpu_ready = 1'b1;
          hit_evt   = 1'b1;
          flush_do  = flush_pending;
        end else begin
          mem_re    = 1'b1;
          state_nxt = S_FILL;
        end
      end
      S_FILL: begin
        // Dropping re in the completion cycle keeps the controller from
        // seeing a second, back-to-back read.
        if (mem.ready) begin
          cpu_ready = 1'b1;
          fill_done = 1'b1;
        end else begin
          mem_re = 1'b1;
        end
      end
      S_WR_ISSUE: begin
        mem_we    = we_q;
        state_nxt = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (mem.ready) cpu_ready = 1'b1;
        else           mem_we    = we_q;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (cpu_ready) begin
      if (acc_wr)      state_nxt = S_WR_ISSUE;
      else if (acc_rd) state_nxt = S_LOOKUP;
      else             state_nxt = S_IDLE;
    end
  end

  assign cpu.ready = cpu_ready;
  assign cpu.rdata = (state == S_FILL) ? mem.rdata : data_mem[idx_q];
  assign mem.re    = mem_re;
  assign mem.we    = mem_we;
  assign mem.addr  = addr_q;
  assign mem.wdata = wdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      valid         <= '0;
      flush_pending <= 1'b0;
      hit_count     <= 32'd0;
      miss_count    <= 32'd0;
    end else begin
      state         <= state_nxt;
      flush_pending <= flush | (flush_pending & ~flush_do);
      if (flush_do)       valid         <= '0;
      else if (fill_done) valid[idx_q]  <= 1'b1;
      if (hit_evt)   hit_count  <= hit_count + 32'd1;
      if (fill_done) miss_count <= miss_count + 32'd1;
    end
  end

  // Request registers, tags and line data carry no reset; valid bits gate them.
  always_ff @(posedge clk) begin
    if (acc_wr || acc_rd) begin
      addr_q  <= cpu.addr;
      we_q    <= cpu.we;
      wdata_q <= cpu.wdata;
    end
    if (fill_done) begin
      tag_mem[idx_q]  <= tag_q;
      data_mem[idx_q] <= mem.rdata;
    end
    if (wr_hit) data_mem[idx_in] <= byte_merge(wr_base, cpu.wdata, cpu.we);
  end

endmodule
